// File: rtl/pixel_vram_arbiter_if.sv
// ---------------------------------------------------------------------------
// pixel_vram_arbiter_if
//
// Bundles the three buses that meet at the pixel VRAM arbiter. The clock and
// reset are not part of this interface.
//   Pixel engine: blank, gpu_addr, gpu_q
//   CPU port    : cpu_addr, cpu_data, cpu_we, cpu_start, cpu_done, cpu_q
//   VRAM port   : vram_addr, vram_d, vram_we, vram_q
//                 The VRAM is a single-port synchronous RAM with a 1-cycle
//                 read latency.
//
// Modports:
//   slave  - the arbiter's view of the buses.
//   master - the system side: pixel engine, CPU and VRAM together.
// ---------------------------------------------------------------------------
interface pixel_vram_arbiter_if;

  // Pixel engine
  logic        blank;      // 1 = pixel engine is not displaying
  logic [16:0] gpu_addr;
  logic [7:0]  gpu_q;

  // CPU request/response
  logic [16:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_we;
  logic        cpu_start;  // held high by the CPU until cpu_done
  logic        cpu_done;   // single-cycle completion pulse
  logic [7:0]  cpu_q;

  // VRAM
  logic [16:0] vram_addr;
  logic [7:0]  vram_d;
  logic        vram_we;
  logic [7:0]  vram_q;

  modport slave (
    input  blank, gpu_addr,
    input  cpu_addr, cpu_data, cpu_we, cpu_start,
    input  vram_q,
    output gpu_q,
    output cpu_done, cpu_q,
    output vram_addr, vram_d, vram_we
  );

  modport master (
    output blank, gpu_addr,
    output cpu_addr, cpu_data, cpu_we, cpu_start,
    output vram_q,
    input  gpu_q,
    input  cpu_done, cpu_q,
    input  vram_addr, vram_d, vram_we
  );

endinterface : pixel_vram_arbiter_if

// File: rtl/pixel_vram_arbiter.sv
// ---------------------------------------------------------------------------
// pixel_vram_arbiter
//
// Shares one single-port VRAM between the pixel engine and a CPU.
//
// While the display is active (blank = 0), the pixel engine owns the VRAM
// outright. The VRAM address is gpu_addr and vram_we is 0.
//
// CPU writes are posted into a small write FIFO. They complete one cycle
// after acceptance, whatever the value of blank. The FIFO drains at one write
// per blanking cycle.
//
// A CPU read waits until the FIFO is empty, so it always observes earlier
// writes. It then issues during blanking, and the data is captured one cycle
// later.
//
// Ports:
//   clk   - system clock; all state updates on its rising edge.
//   reset - asynchronous, active-high reset.
//   bus   - pixel-engine, CPU and VRAM signals (pixel_vram_arbiter_if.slave).
//
// Parameter:
//   WFIFO_DEPTH - write-buffer depth in entries. It must be a power of two,
//                 from 2 to 16.
// ---------------------------------------------------------------------------
module pixel_vram_arbiter #(
  parameter int WFIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  pixel_vram_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam int CNT_W = $clog2(WFIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(WFIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_WR = 2'd1,
    WAIT_RD = 2'd2,
    RD_DATA = 2'd3
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e           state_q, state_d;

  // Write FIFO storage and bookkeeping
  logic [16:0]      fifo_addr_q [WFIFO_DEPTH];
  logic [7:0]       fifo_data_q [WFIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Request latched while stalled in WAIT_WR or WAIT_RD
  logic [16:0]      req_addr_q, req_addr_d;
  logic [7:0]       req_data_q, req_data_d;

  // CPU-facing outputs
  logic             done_q, done_d;
  logic [7:0]       cpu_q_q, cpu_q_d;

  // -------------------------------------------------------------------------
  // Datapath control
  // -------------------------------------------------------------------------
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             rd_issue;
  logic [16:0]      push_addr;
  logic [7:0]       push_data;

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);

  // A read is issued only when the FIFO is empty, so a drain pop can never
  // collide with a read issue. Every blanking cycle with buffered data is
  // therefore a write cycle.
  assign pop = bus.blank && !fifo_empty;

  // -------------------------------------------------------------------------
  // Next-state / control FSM
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    done_d     = 1'b0;
    cpu_q_d    = cpu_q_q;
    push       = 1'b0;
    push_addr  = bus.cpu_addr;
    push_data  = bus.cpu_data;
    rd_issue   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // While cpu_done is high the CPU still holds cpu_start. That start
        // belongs to the request just finished, so it is ignored.
        if (bus.cpu_start && !done_q) begin
          if (bus.cpu_we) begin
            if (!fifo_full) begin
              push   = 1'b1;
              done_d = 1'b1;
            end else begin
              req_addr_d = bus.cpu_addr;
              req_data_d = bus.cpu_data;
              state_d    = WAIT_WR;
            end
          end else begin
            req_addr_d = bus.cpu_addr;
            state_d    = WAIT_RD;
          end
        end
      end

      WAIT_WR: begin
        // A pop in this cycle frees the head slot before the push lands, so
        // the stalled write enters in the same cycle and the count stays at
        // depth. The FIFO never overflows.
        if (!fifo_full || pop) begin
          push      = 1'b1;
          push_addr = req_addr_q;
          push_data = req_data_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end

      WAIT_RD: begin
        // Buffered writes drain first, which keeps read-after-write order.
        if (fifo_empty && bus.blank) begin
          rd_issue = 1'b1;
          state_d  = RD_DATA;
        end
      end

      RD_DATA: begin
        // The read was issued in the previous cycle, so vram_q holds the
        // requested data now. blank does not matter in this cycle.
        cpu_q_d = bus.vram_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FIFO pointer and count update
  // -------------------------------------------------------------------------
  // The depth is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples pre-edge values, whatever order the simulator runs the blocks in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
      done_q     <= 1'b0;
      cpu_q_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      done_q     <= done_d;
      cpu_q_q    <= cpu_q_d;
    end
  end

  // NOTE: the FIFO storage has no reset. Entries are only read when count_q
  // says they are valid, and count_q is reset. Leaving the array unreset keeps
  // it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= push_addr;
      fifo_data_q[wr_ptr_q] <= push_data;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // With blank = 0, pop and rd_issue are both 0, so the pixel engine sees its
  // own address and vram_we is 0. vram_we follows count_q, which resets
  // asynchronously, so vram_we drops as soon as reset is asserted.
  always_comb begin
    if (rd_issue) begin
      bus.vram_addr = req_addr_q;
    end else if (pop) begin
      bus.vram_addr = fifo_addr_q[rd_ptr_q];
    end else begin
      bus.vram_addr = bus.gpu_addr;
    end
  end

  assign bus.vram_d   = fifo_data_q[rd_ptr_q];
  assign bus.vram_we  = pop;
  assign bus.gpu_q    = bus.vram_q;
  assign bus.cpu_done = done_q;
  assign bus.cpu_q    = cpu_q_q;

endmodule : pixel_vram_arbiter

// File: tb/tb_pixel_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pixel_vram_arbiter
//
// Directed bench for pixel_vram_arbiter with WFIFO_DEPTH = 4. A behavioural
// single-port VRAM with a 1-cycle read latency sits on the VRAM side.
// A background monitor records every VRAM write and checks two rules on
// every cycle: no writes while displaying, and no back-to-back cpu_done.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pixel_vram_arbiter;

  logic clk;
  logic reset;

  pixel_vram_arbiter_if bus ();

  pixel_vram_arbiter #(.WFIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural VRAM: synchronous write and a registered read.
  logic [7:0] vram_mem [0:131071];
  logic [7:0] vram_q_r;
  always @(posedge clk) begin
    if (bus.vram_we) vram_mem[bus.vram_addr] <= bus.vram_d;
    vram_q_r <= vram_mem[bus.vram_addr];
  end
  assign bus.vram_q = vram_q_r;

  int          checks;
  int          errors;
  int          done_cnt;
  logic        prev_done;
  logic [24:0] wlog [$];   // {addr, data} of every VRAM write, in order

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a CPU write, waits (bounded) for cpu_done, then drops cpu_start.
  // lat is the number of cycles from acceptance to done, or 0 on timeout.
  task automatic cpu_write(input logic [16:0] a, input logic [7:0] d, output int lat);
    bus.cpu_addr  = a;
    bus.cpu_data  = d;
    bus.cpu_we    = 1'b1;
    bus.cpu_start = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.cpu_done) begin
        lat = n;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.cpu_start = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.blank     = 1'b0;
    bus.gpu_addr  = 17'h05555;
    bus.cpu_addr  = '0;
    bus.cpu_data  = '0;
    bus.cpu_we    = 1'b0;
    bus.cpu_start = 1'b0;
    #3;
    checks++; if (bus.cpu_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.cpu_done); end
    checks++; if (bus.cpu_q !== 8'h00) begin errors++; $display("FAIL reset_cpu_q got %h exp 00", bus.cpu_q); end
    checks++; if (bus.vram_we !== 1'b0) begin errors++; $display("FAIL reset_vram_we got %b exp 0", bus.vram_we); end
    checks++; if (bus.vram_addr !== 17'h05555) begin errors++; $display("FAIL reset_vram_addr got %h exp 05555", bus.vram_addr); end
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_write_while_display();
    int lat;
    bus.blank = 1'b0;
    wlog.delete();
    cpu_write(17'h00010, 8'hA5, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL wr_latency got %0d exp 1", lat); end
    checks++; if (wlog.size() !== 0) begin errors++; $display("FAIL wr_no_access got %0d exp 0", wlog.size()); end
    bus.blank = 1'b1;
    @(negedge clk);
    checks++; if (bus.vram_we !== 1'b1) begin errors++; $display("FAIL drain_we got %b exp 1", bus.vram_we); end
    checks++; if (bus.vram_addr !== 17'h00010) begin errors++; $display("FAIL drain_addr got %h exp 00010", bus.vram_addr); end
    checks++; if (bus.vram_d !== 8'hA5) begin errors++; $display("FAIL drain_data got %h exp a5", bus.vram_d); end
    step();
    @(negedge clk);
    checks++; if (bus.vram_we !== 1'b0) begin errors++; $display("FAIL drain_once got %b exp 0", bus.vram_we); end
    step();
    checks++; if (wlog.size() !== 1) begin errors++; $display("FAIL drain_count got %0d exp 1", wlog.size()); end
    bus.blank = 1'b0;
  endtask

  task automatic test_fifo_full();
    int          lat;
    int          dc;
    logic [24:0] exp_w [5];
    exp_w[0] = {17'h00100, 8'h10};
    exp_w[1] = {17'h00101, 8'h11};
    exp_w[2] = {17'h00102, 8'h12};
    exp_w[3] = {17'h00103, 8'h13};
    exp_w[4] = {17'h00104, 8'h14};
    bus.blank = 1'b0;
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      cpu_write(17'h00100 + 17'(i), 8'h10 + 8'(i), lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL full_wr%0d_latency got %0d exp 1", i, lat); end
    end
    dc = done_cnt;
    bus.cpu_addr  = 17'h00104;
    bus.cpu_data  = 8'h14;
    bus.cpu_we    = 1'b1;
    bus.cpu_start = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (bus.cpu_done !== 1'b0) begin errors++; $display("FAIL full_stall%0d got %b exp 0", n, bus.cpu_done); end
    end
    step();
    bus.blank = 1'b1;
    @(negedge clk);
    checks++; if (bus.vram_we !== 1'b1) begin errors++; $display("FAIL full_pop_we got %b exp 1", bus.vram_we); end
    checks++; if (bus.vram_addr !== 17'h00100) begin errors++; $display("FAIL full_pop_addr got %h exp 00100", bus.vram_addr); end
    checks++; if (bus.cpu_done !== 1'b0) begin errors++; $display("FAIL full_done_early got %b exp 0", bus.cpu_done); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.cpu_done !== 1'b1) begin errors++; $display("FAIL full_done got %b exp 1", bus.cpu_done); end
    step();
    bus.cpu_start = 1'b0;
    repeat (4) step();
    checks++; if (done_cnt - dc !== 1) begin errors++; $display("FAIL full_done_count got %0d exp 1", done_cnt - dc); end
    checks++; if (wlog.size() !== 5) begin errors++; $display("FAIL full_write_count got %0d exp 5", wlog.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < wlog.size()) begin
        checks++; if (wlog[i] !== exp_w[i]) begin errors++; $display("FAIL full_order%0d got %h exp %h", i, wlog[i], exp_w[i]); end
      end
    end
    bus.blank = 1'b0;
  endtask

  task automatic test_read_after_write();
    int   lat;
    logic got;
    bus.blank = 1'b0;
    wlog.delete();
    cpu_write(17'h12C00, 8'h3C, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL raw_wr_latency got %0d exp 1", lat); end
    bus.cpu_addr  = 17'h12C00;
    bus.cpu_we    = 1'b0;
    bus.cpu_start = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (bus.cpu_done !== 1'b0) begin errors++; $display("FAIL raw_rd_stall%0d got %b exp 0", n, bus.cpu_done); end
    end
    step();
    bus.blank = 1'b1;
    @(negedge clk);
    checks++; if (bus.vram_we !== 1'b1) begin errors++; $display("FAIL raw_write_first got %b exp 1", bus.vram_we); end
    checks++; if (bus.vram_addr !== 17'h12C00) begin errors++; $display("FAIL raw_write_addr got %h exp 12c00", bus.vram_addr); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.vram_we !== 1'b0) begin errors++; $display("FAIL raw_read_we got %b exp 0", bus.vram_we); end
    checks++; if (bus.vram_addr !== 17'h12C00) begin errors++; $display("FAIL raw_read_addr got %h exp 12c00", bus.vram_addr); end
    got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.cpu_done) begin
        got = 1'b1;
        break;
      end
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL raw_read_done got %b exp 1", got); end
    checks++; if (bus.cpu_q !== 8'h3C) begin errors++; $display("FAIL raw_read_data got %h exp 3c", bus.cpu_q); end
    step();
    bus.cpu_start = 1'b0;
    step();
    checks++; if (bus.cpu_q !== 8'h3C) begin errors++; $display("FAIL raw_read_hold got %h exp 3c", bus.cpu_q); end
    bus.blank = 1'b0;
  endtask

  task automatic test_blank_mid_drain();
    int lat;
    bus.blank    = 1'b0;
    bus.gpu_addr = 17'h1ABCD;
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      cpu_write(17'h00200 + 17'(i), 8'h40 + 8'(i), lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL mid_wr%0d_latency got %0d exp 1", i, lat); end
    end
    bus.blank = 1'b1;
    @(negedge clk);
    checks++; if (bus.vram_addr !== 17'h00200) begin errors++; $display("FAIL mid_pop0_addr got %h exp 00200", bus.vram_addr); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.vram_addr !== 17'h00201) begin errors++; $display("FAIL mid_pop1_addr got %h exp 00201", bus.vram_addr); end
    step();
    bus.blank = 1'b0;
    @(negedge clk);
    checks++; if (bus.vram_we !== 1'b0) begin errors++; $display("FAIL mid_stop_we got %b exp 0", bus.vram_we); end
    checks++; if (bus.vram_addr !== 17'h1ABCD) begin errors++; $display("FAIL mid_gpu_addr got %h exp 1abcd", bus.vram_addr); end
    step();
    checks++; if (wlog.size() !== 2) begin errors++; $display("FAIL mid_first_count got %0d exp 2", wlog.size()); end
    step();
    bus.blank = 1'b1;
    repeat (3) step();
    checks++; if (wlog.size() !== 4) begin errors++; $display("FAIL mid_total_count got %0d exp 4", wlog.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < wlog.size()) begin
        checks++;
        if (wlog[i] !== {17'h00200 + 17'(i), 8'h40 + 8'(i)}) begin
          errors++; $display("FAIL mid_order%0d got %h exp %h", i, wlog[i], {17'h00200 + 17'(i), 8'h40 + 8'(i)});
        end
      end
    end
    bus.blank = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int dc;
    bus.blank = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_write(17'h00300 + 17'(i), 8'h60 + 8'(i), lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL rst_wr%0d_latency got %0d exp 1", i, lat); end
    end
    bus.cpu_addr  = 17'h00300;
    bus.cpu_we    = 1'b0;
    bus.cpu_start = 1'b1;
    repeat (2) step();
    wlog.delete();
    dc = done_cnt;
    reset     = 1'b1;
    bus.blank = 1'b1;
    #1;
    checks++; if (bus.vram_we !== 1'b0) begin errors++; $display("FAIL rst_async_we got %b exp 0", bus.vram_we); end
    checks++; if (bus.cpu_q !== 8'h00) begin errors++; $display("FAIL rst_cpu_q got %h exp 00", bus.cpu_q); end
    repeat (2) step();
    bus.cpu_start = 1'b0;
    reset         = 1'b0;
    repeat (4) step();
    checks++; if (wlog.size() !== 0) begin errors++; $display("FAIL rst_discard got %0d exp 0", wlog.size()); end
    checks++; if (done_cnt - dc !== 0) begin errors++; $display("FAIL rst_no_done got %0d exp 0", done_cnt - dc); end
    checks++; if (bus.cpu_q !== 8'h00) begin errors++; $display("FAIL rst_cpu_q_after got %h exp 00", bus.cpu_q); end
    cpu_write(17'h003FF, 8'h77, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL rst_fresh_latency got %0d exp 1", lat); end
    repeat (2) step();
    checks++; if (wlog.size() !== 1) begin errors++; $display("FAIL rst_fresh_count got %0d exp 1", wlog.size()); end
    if (wlog.size() > 0) begin
      checks++; if (wlog[0] !== {17'h003FF, 8'h77}) begin errors++; $display("FAIL rst_fresh_entry got %h exp %h", wlog[0], {17'h003FF, 8'h77}); end
    end
    bus.blank = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    done_cnt  = 0;
    prev_done = 1'b0;
    reset     = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (bus.vram_we === 1'b1) wlog.push_back({bus.vram_addr, bus.vram_d});
        checks++;
        if (bus.vram_we === 1'b1 && bus.blank !== 1'b1) begin
          errors++; $display("FAIL mon_we_while_display at %0t got we=%b blank=%b", $time, bus.vram_we, bus.blank);
        end
        checks++;
        if (bus.cpu_done === 1'b1 && prev_done === 1'b1) begin
          errors++; $display("FAIL mon_done_double at %0t got 2 consecutive exp 1", $time);
        end
        if (bus.cpu_done === 1'b1) done_cnt++;
        prev_done = bus.cpu_done;
      end
      begin
        #1_000_000;
        $display("FAIL watchdog timeout got no finish exp finish");
        $fatal(1, "watchdog");
      end
    join_none

    test_reset();
    test_write_while_display();
    test_fifo_full();
    test_read_after_write();
    test_blank_mid_drain();
    test_reset_mid_op();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pixel_vram_arbiter

// File: doc/pixel_vram_arbiter.md
PIXEL_VRAM_ARBITER -- requirements
Module: pixel_vram_arbiter

Interface
REQ-001 SHALL have parameter WFIFO_DEPTH, default 4, CPU write-buffer depth in entries (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port blank  input  1  video blanking; 1 means the pixel engine is not displaying.
REQ-005 SHALL have port gpu_addr  input  17  pixel-engine VRAM read address.
REQ-006 SHALL have port gpu_q  output  8  pixel-engine read data; equals vram_q combinationally.
REQ-007 SHALL have port cpu_addr  input  17  CPU VRAM address, sampled on the cycle cpu_start is accepted.
REQ-008 SHALL have port cpu_data  input  8  CPU write data, sampled with cpu_addr.
REQ-009 SHALL have port cpu_we  input  1  1 = write, 0 = read, sampled with cpu_addr.
REQ-010 SHALL have port cpu_start  input  1  CPU request strobe; held high until cpu_done.
REQ-011 SHALL have port cpu_done  output  1  single-cycle completion pulse.
REQ-012 SHALL have port cpu_q  output  8  CPU read data; valid from the cpu_done cycle until the next read completes.
REQ-013 SHALL have ports vram_addr output 17, vram_d output 8, vram_we output 1, vram_q input 8: single-port synchronous VRAM with 1-cycle read latency.

Function
REQ-014 SHALL drive vram_addr = gpu_addr and vram_we = 0 combinationally whenever blank = 0; no CPU access while displaying.
REQ-015 SHALL issue CPU-side VRAM accesses only in cycles with blank = 1.
REQ-016 SHALL hold CPU writes in a FIFO of WFIFO_DEPTH {addr, data} entries; count width clog2(WFIFO_DEPTH)+1; pointers wrap modulo depth.
REQ-017 SHALL implement states IDLE, WAIT_WR, WAIT_RD, RD_DATA.
REQ-018 IDLE, cpu_start=1, cpu_we=1, FIFO not full: push entry, pulse cpu_done next cycle, stay IDLE.
REQ-019 IDLE, cpu_start=1, cpu_we=1, FIFO full: latch request, go WAIT_WR; push when count < depth, pulse cpu_done next cycle, return IDLE.
REQ-020 IDLE, cpu_start=1, cpu_we=0: latch address, go WAIT_RD.
REQ-021 WAIT_RD: when FIFO empty and blank=1, drive vram_addr = latched address, go RD_DATA (read-after-write ordering preserved).
REQ-022 RD_DATA: capture vram_q into cpu_q, pulse cpu_done, go IDLE; capture regardless of blank in that cycle.
REQ-023 Drain: any cycle with blank=1, FIFO non-empty, state not issuing a read: pop head, drive vram_addr/vram_d, vram_we=1; one write per cycle.
REQ-024 Simultaneous push and pop in one cycle SHALL leave count unchanged; push-on-full is never performed.
REQ-025 blank falling mid-drain SHALL stop pops that cycle; remaining entries drain in the next blank interval, in order.
REQ-026 cpu_start while cpu_done pulses or state ≠ IDLE SHALL be ignored; a new request is accepted only in IDLE.
REQ-027 cpu_done SHALL never be high for two consecutive cycles.
REQ-028 Write latency when FIFO not full SHALL be exactly 1 cycle start-to-done, independent of blank.

Reset
REQ-029 On reset: state IDLE, FIFO empty (pointers, count = 0), cpu_done = 0, cpu_q = 0, vram_we = 0, latched request cleared.
REQ-030 Reset mid-operation SHALL discard buffered writes and any pending read without a cpu_done pulse; vram_we = 0 immediately (asynchronously).

Verification
REQ-031 blank=0, write 0xA5 @0x00010 -> cpu_done after 1 cycle, vram_we stays 0; blank=1 -> next cycle vram_we=1, vram_addr=0x00010, vram_d=0xA5.
REQ-032 blank=0, 5 writes (depth 4) -> first 4 done in 1 cycle each, 5th stalls in WAIT_WR; blank=1 -> first pop, 5th pushes same cycle, cpu_done 1 cycle later, all 5 written in order.
REQ-033 Write 0x3C @0x12C00 then read @0x12C00 with blank=0 -> no access until blank=1; write first, then read; cpu_q=0x3C with cpu_done.
REQ-034 blank toggles 1->0 after 2 of 4 buffered writes drain -> vram_addr follows gpu_addr, vram_we=0; remaining 2 complete next blank.
REQ-035 Reset asserted with 3 buffered writes and a read in WAIT_RD -> no further vram_we, no cpu_done, cpu_q=0; a fresh write after release completes in 1 cycle.
